// File: rtl/uart_hex_frame_tx.sv
// Hex-framed UART transmitter: encodes each accepted byte as ':'? HH ';'? in ASCII
// and serializes every character as 8N1 on o_txd.
module uart_hex_frame_tx #(
  parameter int CLOCK_FREQ = 12000000,
  parameter int BOUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  input  logic       i_data_start,
  input  logic       i_data_end,
  output logic       o_data_ready,
  output logic       o_txd,
  output logic       o_busy
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BOUD_RATE;
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, SYNC, HI, LO, END} seq_t;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_t;

  seq_t             seq_q, seq_d;
  ser_t             ser_q, ser_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             txd_q, txd_d;
  logic [7:0]       byte_q, byte_d;
  logic             end_q, end_d;

  logic             accept;
  logic             bit_done;
  logic             char_done;
  logic [7:0]       cur_char;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  assign accept    = i_data_valid && (seq_q == IDLE);
  assign bit_done  = (cnt_q == CNT_LAST);
  assign char_done = (ser_q == S_STOP) && bit_done;

  always_comb begin
    cur_char = 8'hFF;
    case (seq_q)
      SYNC:    cur_char = 8'h3A;
      HI:      cur_char = hex_char(byte_q[7:4]);
      LO:      cur_char = hex_char(byte_q[3:0]);
      END:     cur_char = 8'h3B;
      default: cur_char = 8'hFF;
    endcase
  end

  // Sequencer: picks which character the serializer is sending
  always_comb begin
    seq_d  = seq_q;
    byte_d = byte_q;
    end_d  = end_q;
    case (seq_q)
      IDLE: begin
        if (accept) begin
          seq_d  = i_data_start ? SYNC : HI;
          byte_d = i_data;
          end_d  = i_data_end;
        end
      end
      SYNC:    if (char_done) seq_d = HI;
      HI:      if (char_done) seq_d = LO;
      LO:      if (char_done) seq_d = end_q ? END : IDLE;
      END:     if (char_done) seq_d = IDLE;
      default: seq_d = IDLE;
    endcase
  end

  // Serializer starts on the acceptance edge; o_txd trails the state by one clock,
  // which keeps the line registered and gives the one-clock idle gap between bytes.
  always_comb begin
    ser_d = ser_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    case (ser_q)
      S_IDLE: begin
        if (accept) begin
          ser_d = S_START;
          cnt_d = '0;
        end
      end
      S_START: begin
        if (bit_done) begin
          cnt_d = '0;
          idx_d = 3'd0;
          ser_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (idx_q == 3'd7) ser_d = S_STOP;
          else               idx_d = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          ser_d = (seq_d != IDLE) ? S_START : S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ser_d = S_IDLE;
    endcase
  end

  always_comb begin
    txd_d = 1'b1;
    case (ser_q)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = cur_char[idx_q];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q <= IDLE;
      ser_q <= S_IDLE;
      cnt_q <= '0;
      idx_q <= 3'd0;
      txd_q <= 1'b1;
    end else begin
      seq_q <= seq_d;
      ser_q <= ser_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      txd_q <= txd_d;
    end
  end

  // Payload is only read while the sequencer is busy, so it needs no reset
  always_ff @(posedge clk) begin
    byte_q <= byte_d;
    end_q  <= end_d;
  end

  assign o_data_ready = (seq_q == IDLE);
  assign o_busy       = (seq_q != IDLE);
  assign o_txd        = txd_q;

endmodule
